uart_rx_deserializer: RTL and testbench

//  - Serial receive stage of the UART: samples the rx pin, deserialises 8N1 frames, and

---
 rtl/uart_rx_deserializer.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receive deserialiser: 16x oversampled 8N1 (or 8E1/8O1 with UART_RX_PARITY_EN) into the RX FIFO write port.
// Byte appears mid-stop-bit; a full FIFO drops the byte and flags overrun_error. There is no other backpressure.
module uart_rx_deserializer #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          baud_final_value,
  input  logic                 rx,
  input  logic                 rx_fifo_Full,
  output logic [DATA_BITS-1:0] rx_fifo_dataIn,
  output logic                 rx_fifo_writeEn,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error,
  output logic                 rx_busy
);

  localparam logic [3:0] S_MID  = 4'(OVERSAMPLE/2 - 1);
  localparam logic [3:0] S_END  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);

  if (SYNC_STAGES < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx_deserializer: SYNC_STAGES must be >= 2 and PARITY_ODD 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state;
  logic [3:0]             s;
  logic [2:0]             n;
  logic [DATA_BITS-1:0]   shift;
  logic [10:0]            tick_cnt;
  logic                   tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev;

  // The >= compare keeps the counter from running away when the divisor is lowered mid-count.
  assign tick = (tick_cnt >= baud_final_value);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parity_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      s               <= '0;
      n               <= '0;
      shift           <= '0;
      rx_fifo_dataIn  <= '0;
      rx_fifo_writeEn <= 1'b0;
      framing_error   <= 1'b0;
      overrun_error   <= 1'b0;
      rx_busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad         <= 1'b0;
      parity_error    <= 1'b0;
`endif
    end else begin
      rx_fifo_writeEn <= 1'b0;
      framing_error   <= 1'b0;
      overrun_error   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error    <= 1'b0;
`endif
      case (state)
        // A falling edge is required, so a held-low line (break) cannot retrigger.
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state   <= START;
            s       <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (s == S_MID) begin
              if (rx_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == S_END) begin
              s     <= '0;
              shift <= {rx_s, shift[DATA_BITS-1:1]};
              if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 3'd1;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s == S_END) begin
              s       <= '0;
              par_bad <= (rx_s != ((^shift) ^ PARITY_ODD[0]));
              state   <= STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s == S_END) begin
              s       <= '0;
              state   <= IDLE;
              rx_busy <= 1'b0;
              if (!rx_s) begin
                framing_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad) begin
                parity_error <= 1'b1;
`endif
              end else if (rx_fifo_Full) begin
                overrun_error <= 1'b1;
              end else begin
                rx_fifo_dataIn  <= shift;
                rx_fifo_writeEn <= 1'b1;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer; a short baud divisor keeps the run small (4 clks/tick, 64 clks/bit).
module tb_uart_rx_deserializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] baud_final_value = 11'd3;
  logic        rx = 1'b1;
  logic        rx_fifo_Full = 1'b0;
  logic [7:0]  rx_fifo_dataIn;
  logic        rx_fifo_writeEn;
  logic        framing_error;
  logic        parity_error;
  logic        overrun_error;
  logic        rx_busy;

  int bit_clks = 64;
  int n_checks = 0;
  int n_errors = 0;

  int we_cnt = 0, fe_cnt = 0, pe_cnt = 0, oe_cnt = 0;
  logic [7:0] last_dat = 8'h00;
  int we0, fe0, pe0, oe0;

  always #5 clk = ~clk;

  uart_rx_deserializer #(
    .DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2), .PARITY_ODD(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .baud_final_value(baud_final_value),
    .rx(rx),
    .rx_fifo_Full(rx_fifo_Full),
    .rx_fifo_dataIn(rx_fifo_dataIn),
    .rx_fifo_writeEn(rx_fifo_writeEn),
    .framing_error(framing_error),
    .parity_error(parity_error),
    .overrun_error(overrun_error),
    .rx_busy(rx_busy)
  );

  // Counting high cycles (not edges) also catches pulses wider than one clock.
  always @(negedge clk) begin
    if (rx_fifo_writeEn === 1'b1) begin
      we_cnt++;
      last_dat = rx_fifo_dataIn;
    end
    if (framing_error === 1'b1) fe_cnt++;
    if (parity_error === 1'b1) pe_cnt++;
    if (overrun_error === 1'b1) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic snap();
    we0 = we_cnt; fe0 = fe_cnt; pe0 = pe_cnt; oe0 = oe_cnt;
  endtask

  task automatic pulses(input string tag, input int we, input int fe, input int pe, input int oe);
    check({tag, "_we"}, we_cnt - we0, we);
    check({tag, "_fe"}, fe_cnt - fe0, fe);
    check({tag, "_pe"}, pe_cnt - pe0, pe);
    check({tag, "_oe"}, oe_cnt - oe0, oe);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    hold(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) hold(d[i], bit_clks);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, bit_clks);
`endif
    hold(stop_v, bit_clks);
    hold(1'b1, bit_clks);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_we", rx_fifo_writeEn, 1'b0);
    check("rst_dat", rx_fifo_dataIn, 8'h00);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_err", {framing_error, parity_error, overrun_error}, 3'b000);
    reset = 1'b0;
    hold(1'b1, 2 * bit_clks);

    // Good byte
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    pulses("a5", 1, 0, 0, 0);
    check("a5_dat", last_dat, 8'hA5);
    check("a5_busy", rx_busy, 1'b0);

    // Short low glitch, well under half a bit
    snap();
    hold(1'b0, 10);
    check("glitch_busy_hi", rx_busy, 1'b1);
    hold(1'b0, 8);
    hold(1'b1, 2 * bit_clks);
    check("glitch_busy_lo", rx_busy, 1'b0);
    pulses("glitch", 0, 0, 0, 0);

    // Stop bit low
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    pulses("frm", 0, 1, 0, 0);
    check("frm_dat_held", rx_fifo_dataIn, 8'hA5);

    // Break: exactly one framing error, no restart while the line stays low
    snap();
    hold(1'b0, 14 * bit_clks);
    pulses("brk", 0, 1, 0, 0);
    check("brk_busy", rx_busy, 1'b0);
    hold(1'b1, 2 * bit_clks);
    check("brk_dat_held", rx_fifo_dataIn, 8'hA5);

    // Overrun, then a normal byte
    snap();
    rx_fifo_Full = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    rx_fifo_Full = 1'b0;
    pulses("ovr", 0, 0, 0, 1);
    check("ovr_dat_held", rx_fifo_dataIn, 8'hA5);
    snap();
    send_frame(8'h7E, 1'b1, 1'b0);
    pulses("7e", 1, 0, 0, 0);
    check("7e_dat", last_dat, 8'h7E);
    check("7e_dat_reg", rx_fifo_dataIn, 8'h7E);

    // One-clock reset in the middle of data bit 4 of 0xFF
    snap();
    hold(1'b0, bit_clks);
    for (int i = 0; i < 4; i++) hold(1'b1, bit_clks);
    hold(1'b1, bit_clks / 2);
    check("midrst_busy_pre", rx_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", rx_busy, 1'b0);
    check("midrst_dat", rx_fifo_dataIn, 8'h00);
    check("midrst_err", {rx_fifo_writeEn, framing_error, parity_error, overrun_error}, 4'h0);
    hold(1'b1, 6 * bit_clks);
    pulses("midrst", 0, 0, 0, 0);
    snap();
    send_frame(8'h12, 1'b1, 1'b0);
    pulses("12", 1, 0, 0, 0);
    check("12_dat", last_dat, 8'h12);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    pulses("par_ok", 1, 0, 0, 0);
    check("par_ok_dat", last_dat, 8'h07);
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    pulses("par_bad", 0, 0, 1, 0);
`else
    check("no_parity_pulses", pe_cnt, 0);
`endif

    // Divisor 0: a tick every clock, 16 clks per bit
    baud_final_value = 11'd0;
    bit_clks = 16;
    hold(1'b1, 2 * bit_clks);
    snap();
    send_frame(8'h5A, 1'b1, 1'b0);
    pulses("fast", 1, 0, 0, 0);
    check("fast_dat", last_dat, 8'h5A);
    check("fast_busy", rx_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
